mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipelined LEGv8 memory-access stage: the consuming end of the execute-to-memory interface. It registers each executed instruction (ALU result, store data, branch target, zero flag, branch and memory control bits) into an EX/MEM register. It performs the data-memory load or store over a request/acknowledge port, resolves conditional branches, and presents a registered write-back bundle to the register file. It back-pressures the execute stage while a memory transaction is outstanding.

## Interface
- `DATA_W`, 64: width of data, addresses and results.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  execute stage presents an instruction this cycle.
- `ex_ready`  out  1  stage accepts; transfer occurs on an edge where `ex_valid && ex_ready`.
- `ex_instruction`  in  32  instruction word; bits [4:0] are the destination register.
- `ex_branch_addr`  in  DATA_W  computed branch target.
- `ex_result`  in  DATA_W  ALU result; this is the memory address for loads and stores.
- `ex_data2`  in  DATA_W  store data.
- `ex_zero`  in  1  ALU result was zero.
- `ex_b`, `ex_bz`, `ex_bnz`  in  1 each  unconditional branch, branch-if-zero, branch-if-not-zero.
- `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`  in  1 each  memory and write-back controls.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  request is a write.
- `dmem_addr`  out  DATA_W  memory address.
- `dmem_wdata`  out  DATA_W  write data.
- `dmem_ack`  in  1  memory completes the request this cycle.
- `dmem_rdata`  in  DATA_W  read data; valid when `dmem_ack` is high.
- `pc_src`  out  1  registered branch-taken pulse.
- `branch_target`  out  DATA_W  registered target; meaningful when `pc_src` is high.
- `wb_valid`  out  1  write-back bundle valid; asserted for exactly one cycle per retired instruction.
- `wb_reg_write`  out  1  register-file write enable; only ever high together with `wb_valid`.
- `wb_reg`  out  5  destination register.
- `wb_data`  out  DATA_W  write-back data.

## Operation
- States:
  - EMPTY: no instruction held.
  - HOLD: a non-memory instruction is held.
  - ACCESS: a memory instruction is held and its request is outstanding.
- `ex_ready` is high when the state is not ACCESS.
- Capture: on an accepted transfer, latch all `ex_*` inputs. The next state is ACCESS if `ex_mem_read` or `ex_mem_write` is set, otherwise HOLD.
- HOLD retires at the next edge. If no transfer occurs on that edge, the state goes to EMPTY. A transfer on that same edge captures the new instruction, giving one instruction per cycle for non-memory ops.
- ACCESS:
  - `dmem_req` is high.
  - `dmem_addr` is the held result.
  - `dmem_wdata` is the held data2.
  - `dmem_we` is the held write bit.
  - All four signals stay stable until the edge that samples `dmem_ack` high. That edge retires the instruction and moves the state to EMPTY.
- If both `ex_mem_read` and `ex_mem_write` are set, the write wins: the op is a store, and `wb_data` is the result.
- Retire edge loads:
  - `wb_valid` = 1.
  - `wb_reg` = instruction[4:0].
  - `wb_reg_write` = held reg_write.
  - `wb_data` = `dmem_rdata` if the op is a read and mem_to_reg is set, else the held result.
  - `pc_src` = b | (bz & zero) | (bnz & ~zero).
  - `branch_target` = held branch address.
- On any edge that does not retire an instruction, `wb_valid`, `wb_reg_write` and `pc_src` go to 0. `wb_data`, `wb_reg` and `branch_target` keep their last values.
- `dmem_ack` is ignored outside ACCESS.
- `ex_valid` is ignored while `ex_ready` is low. The execute stage must hold its inputs stable until the transfer occurs.

## Timing
- Reset:
  - The state is EMPTY.
  - `ex_ready` = 1.
  - `dmem_req`, `dmem_we`, `pc_src`, `wb_valid`, `wb_reg_write` = 0.
  - All data outputs and `wb_reg` = 0.
  - Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-ACCESS drops `dmem_req` asynchronously and abandons the transaction. A late ack after reset is ignored.
- Latency for a non-memory op: captured at edge k, write-back outputs valid during the cycle after edge k+1.
- Latency for a memory op: `dmem_req` is high from edge k. If the ack is first sampled high at edge j (j ≥ k+1), the write-back outputs are valid after edge j.
- A zero-wait memory (ack in the first cycle) therefore matches the non-memory latency. Back-to-back memory ops cost at least 2 cycles each.
- `pc_src` and `wb_valid` are asserted in the same cycle for a given instruction.

## Test plan
- **Reset.** Assert `rst_n` low while in ACCESS. Required: `dmem_req` = 0 and `ex_ready` = 1 without a clock edge, `wb_valid` = 0. An ack pulse after reset release produces no write-back.
- **Non-memory ops.** Three back-to-back ops:
  - result 0x15, Rd 5, reg_write 1;
  - result 0x2A, Rd 6, reg_write 1;
  - result 0x0, Rd 7, reg_write 0.
  - Required: `ex_ready` stays 1; `wb_valid` is high on three consecutive cycles, each one cycle after its capture edge, with (5, 0x15, we 1), (6, 0x2A, we 1), (7, —, we 0).
- **Load, ack after 3 cycles.** result 0x100, mem_read=1, mem_to_reg=1, Rd 9, `dmem_rdata`=0xDEADBEEF when acked.
  - Required: `dmem_req` high for 3 cycles with addr 0x100 and we 0; `ex_ready` low for those cycles.
  - Then: `wb_data` = 0xDEADBEEF, `wb_reg` = 9, `wb_reg_write` = 1; `ex_valid` presented during the wait is not captured until `ex_ready` returns high.
- **Zero-wait store.** result 0x40, data2 0x1234, mem_write=1, reg_write=0. Required: `dmem_req` high for one cycle with we 1, addr 0x40, wdata 0x1234; `wb_valid` = 1 with `wb_reg_write` = 0.
- **Branch cases** (target 0x2000 where taken):
  - CBZ with zero=1: `pc_src` pulses for 1 cycle and `branch_target` = 0x2000.
  - CBNZ with zero=1: `pc_src` stays 0.
  - B: `pc_src` = 1.
  - CBZ with zero=0: `pc_src` = 0.
- **Both read and write set.** result 0x80, data2 0x55. Required: `dmem_we` = 1 and `wb_data` = 0x80.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: execute-side handshake, data-memory port and write-back bundle of the memory stage
interface mem_access_if #(parameter int DATA_W = 64);
  logic              ex_valid;
  logic              ex_ready;
  logic [31:0]       ex_instruction;
  logic [DATA_W-1:0] ex_branch_addr;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_data2;
  logic              ex_zero;
  logic              ex_b;
  logic              ex_bz;
  logic              ex_bnz;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_reg_write;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              pc_src;
  logic [DATA_W-1:0] branch_target;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  modport slave (
    input  ex_valid, ex_instruction, ex_branch_addr, ex_result, ex_data2, ex_zero,
           ex_b, ex_bz, ex_bnz, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
           dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           pc_src, branch_target, wb_valid, wb_reg_write, wb_reg, wb_data
  );
  modport master (
    output ex_valid, ex_instruction, ex_branch_addr, ex_result, ex_data2, ex_zero,
           ex_b, ex_bz, ex_bnz, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
           dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           pc_src, branch_target, wb_valid, wb_reg_write, wb_reg, wb_data
  );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: LEGv8 EX/MEM register, data-memory access, branch resolve and write-back bundle
module mem_access_stage #(parameter int DATA_W = 64) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HOLD, ACCESS} state_t;
  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] br;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] d2;
    logic              z;
    logic              b;
    logic              bz;
    logic              bnz;
    logic              mr;
    logic              mw;
    logic              m2r;
    logic              rw;
  } held_t;
  state_t            state_q, state_d;
  held_t             held_q, held_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              pc_src_q, pc_src_d;
  logic [4:0]        wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;
  logic              accept, retire, load_data;
  // capture on handshake, retire HOLD immediately or ACCESS on ack; write wins over read
  always_comb begin
    accept          = bus.ex_valid && state_q != ACCESS;
    retire          = state_q == HOLD || (state_q == ACCESS && bus.dmem_ack);
    load_data       = held_q.mr && !held_q.mw && held_q.m2r;
    state_d         = accept ? ((bus.ex_mem_read || bus.ex_mem_write) ? ACCESS : HOLD)
                             : (retire ? EMPTY : state_q);
    held_d          = accept ? held_t'{rd: bus.ex_instruction[4:0], br: bus.ex_branch_addr,
                                       res: bus.ex_result, d2: bus.ex_data2, z: bus.ex_zero,
                                       b: bus.ex_b, bz: bus.ex_bz, bnz: bus.ex_bnz,
                                       mr: bus.ex_mem_read, mw: bus.ex_mem_write,
                                       m2r: bus.ex_mem_to_reg, rw: bus.ex_reg_write}
                             : held_q;
    wb_valid_d      = retire;
    wb_reg_write_d  = retire && held_q.rw;
    pc_src_d        = retire && (held_q.b || (held_q.bz && held_q.z) || (held_q.bnz && !held_q.z));
    wb_reg_d        = retire ? held_q.rd : wb_reg_q;
    wb_data_d       = retire ? (load_data ? bus.dmem_rdata : held_q.res) : wb_data_q;
    branch_target_d = retire ? held_q.br : branch_target_q;
  end
  // state, EX/MEM register and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= EMPTY;
      held_q          <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      pc_src_q        <= 1'b0;
      wb_reg_q        <= '0;
      wb_data_q       <= '0;
      branch_target_q <= '0;
    end else begin
      state_q         <= state_d;
      held_q          <= held_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      pc_src_q        <= pc_src_d;
      wb_reg_q        <= wb_reg_d;
      wb_data_q       <= wb_data_d;
      branch_target_q <= branch_target_d;
    end
  end
  assign bus.ex_ready      = state_q != ACCESS;
  assign bus.dmem_req      = state_q == ACCESS;
  assign bus.dmem_we       = state_q == ACCESS && held_q.mw;
  assign bus.dmem_addr     = held_q.res;
  assign bus.dmem_wdata    = held_q.d2;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_reg_write  = wb_reg_write_q;
  assign bus.pc_src        = pc_src_q;
  assign bus.wb_reg        = wb_reg_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.branch_target = branch_target_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed test-plan steps plus randomized ops against a transaction-level model
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  mem_access_if #(.DATA_W(64)) bus ();
  mem_access_stage #(.DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res, d2, br;
    logic        z, b, bz, bnz, mr, mw, m2r, rw;
  } op_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [4:0] rd, input logic [63:0] res, d2, br,
                             input logic z, b, bz, bnz, mr, mw, m2r, rw);
    op_t o;
    o.rd = rd; o.res = res; o.d2 = d2; o.br = br; o.z = z; o.b = b; o.bz = bz; o.bnz = bnz;
    o.mr = mr; o.mw = mw; o.m2r = m2r; o.rw = rw;
    return o;
  endfunction

  task automatic drive(input op_t o);
    bus.ex_valid       = 1'b1;
    bus.ex_instruction = {$urandom_range(0, 134217727), o.rd};
    bus.ex_result      = o.res;
    bus.ex_data2       = o.d2;
    bus.ex_branch_addr = o.br;
    bus.ex_zero        = o.z;
    bus.ex_b           = o.b;
    bus.ex_bz          = o.bz;
    bus.ex_bnz         = o.bnz;
    bus.ex_mem_read    = o.mr;
    bus.ex_mem_write   = o.mw;
    bus.ex_mem_to_reg  = o.m2r;
    bus.ex_reg_write   = o.rw;
  endtask

  task automatic check_wb(input string tag, input op_t o, input logic [63:0] rdata);
    chk({tag, ".wb_valid"}, bus.wb_valid, 1);
    chk({tag, ".wb_reg"}, bus.wb_reg, o.rd);
    chk({tag, ".wb_reg_write"}, bus.wb_reg_write, o.rw);
    chk({tag, ".wb_data"}, bus.wb_data, (o.mr && !o.mw && o.m2r) ? rdata : o.res);
    chk({tag, ".pc_src"}, bus.pc_src, o.b | (o.bz & o.z) | (o.bnz & ~o.z));
    chk({tag, ".branch_target"}, bus.branch_target, o.br);
  endtask

  // one op from an idle stage: handshake, optional memory wait, retire and the idle cycle after
  task automatic do_op(input string tag, input op_t o, input int waits, input logic [63:0] rdata);
    @(posedge clk); #1 drive(o);
    @(negedge clk); chk({tag, ".ready"}, bus.ex_ready, 1);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    if (o.mr || o.mw) begin
      for (int i = 0; i <= waits; i++) begin
        if (i == waits) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = rdata; end
        @(negedge clk);
        chk({tag, ".req"}, bus.dmem_req, 1);
        chk({tag, ".we"}, bus.dmem_we, o.mw);
        chk({tag, ".addr"}, bus.dmem_addr, o.res);
        chk({tag, ".wdata"}, bus.dmem_wdata, o.d2);
        chk({tag, ".busy"}, bus.ex_ready, 0);
        chk({tag, ".early_wb"}, bus.wb_valid, 0);
        @(posedge clk); #1;
      end
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = {$urandom, $urandom};
    end else begin
      @(posedge clk); #1;
    end
    @(negedge clk); check_wb(tag, o, rdata);
    chk({tag, ".req_off"}, bus.dmem_req, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".wb_drop"}, bus.wb_valid, 0);
    chk({tag, ".pc_drop"}, bus.pc_src, 0);
    chk({tag, ".we_drop"}, bus.wb_reg_write, 0);
  endtask

  initial begin
    op_t o1, o2, o3, ld, nx;
    bus.ex_valid = 1'b0; bus.ex_instruction = '0; bus.ex_result = '0; bus.ex_data2 = '0;
    bus.ex_branch_addr = '0; bus.ex_zero = 1'b0; bus.ex_b = 1'b0; bus.ex_bz = 1'b0;
    bus.ex_bnz = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
    bus.ex_mem_to_reg = 1'b0; bus.ex_reg_write = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.ready", bus.ex_ready, 1);
    chk("rst.req", bus.dmem_req, 0);
    chk("rst.we", bus.dmem_we, 0);
    chk("rst.addr", bus.dmem_addr, 0);
    chk("rst.wdata", bus.dmem_wdata, 0);
    chk("rst.pc_src", bus.pc_src, 0);
    chk("rst.target", bus.branch_target, 0);
    chk("rst.wb_valid", bus.wb_valid, 0);
    chk("rst.wb_we", bus.wb_reg_write, 0);
    chk("rst.wb_reg", bus.wb_reg, 0);
    chk("rst.wb_data", bus.wb_data, 0);
    @(negedge clk); rst_n = 1'b1;

    // three back-to-back non-memory ops
    o1 = mk(5, 64'h15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    o2 = mk(6, 64'h2A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    o3 = mk(7, 64'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 drive(o1);
    @(posedge clk); #1 drive(o2);
    @(negedge clk); chk("b2b.ready1", bus.ex_ready, 1); chk("b2b.idle", bus.wb_valid, 0);
    @(posedge clk); #1 drive(o3);
    @(negedge clk); chk("b2b.ready2", bus.ex_ready, 1); check_wb("b2b.op1", o1, 0);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk); chk("b2b.ready3", bus.ex_ready, 1); check_wb("b2b.op2", o2, 0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.op3.valid", bus.wb_valid, 1);
    chk("b2b.op3.reg", bus.wb_reg, 7);
    chk("b2b.op3.we", bus.wb_reg_write, 0);
    @(posedge clk);
    @(negedge clk); chk("b2b.end", bus.wb_valid, 0);

    // load acked after 3 cycles, with a younger op waiting on ex_valid throughout
    ld = mk(9, 64'h100, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    nx = mk(12, 64'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 drive(ld);
    @(posedge clk); #1 drive(nx);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hDEADBEEF; end
      @(negedge clk);
      chk("ld.req", bus.dmem_req, 1);
      chk("ld.addr", bus.dmem_addr, 64'h100);
      chk("ld.we", bus.dmem_we, 0);
      chk("ld.ready", bus.ex_ready, 0);
      chk("ld.wait_wb", bus.wb_valid, 0);
      @(posedge clk); #1;
    end
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'h1111;
    @(negedge clk);
    check_wb("ld", ld, 64'hDEADBEEF);
    chk("ld.ready_back", bus.ex_ready, 1);
    chk("ld.req_off", bus.dmem_req, 0);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk); chk("ld.nx_gap", bus.wb_valid, 0);
    @(posedge clk);
    @(negedge clk); check_wb("ld.nx", nx, 0);
    @(posedge clk);

    do_op("st0", mk(3, 64'h40, 64'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 64'h9999);
    do_op("cbz_t", mk(1, 64'h0, 0, 64'h2000, 1, 0, 1, 0, 0, 0, 0, 0), 0, 0);
    do_op("cbnz_nt", mk(2, 64'h0, 0, 64'h2000, 1, 0, 0, 1, 0, 0, 0, 0), 0, 0);
    do_op("b", mk(4, 64'h8, 0, 64'h2000, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    do_op("cbz_nt", mk(8, 64'h8, 0, 64'h2000, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0);
    do_op("rdwr", mk(10, 64'h80, 64'h55, 0, 0, 0, 0, 0, 1, 1, 1, 1), 1, 64'hABCD);

    // reset in the middle of an outstanding access
    @(posedge clk); #1 drive(ld);
    @(posedge clk); #1 bus.ex_valid = 1'b0;
    @(negedge clk); chk("rstacc.req_before", bus.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc.req", bus.dmem_req, 0);
    chk("rstacc.ready", bus.ex_ready, 1);
    chk("rstacc.wb_valid", bus.wb_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hBAD;
    @(posedge clk); #1 bus.dmem_ack = 1'b0;
    @(negedge clk); chk("rstacc.late_ack", bus.wb_valid, 0);
    @(negedge clk); chk("rstacc.late_ack2", bus.wb_valid, 0);

    // randomized ops checked against the model in check_wb
    for (int n = 0; n < 40; n++) begin
      int k;
      op_t r;
      k = $urandom_range(0, 3);
      r = mk(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             k == 1 || k == 3, k == 2 || k == 3, 1'($urandom), 1'($urandom));
      do_op($sformatf("rnd%0d", n), r, $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
